// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: key inputs, counter digits and control/display outputs of the stopwatch controller
interface stopwatch_ctrl_if;
  logic        key_startstop_n;
  logic        key_lap_n;
  logic        key_clear_n;
  logic [31:0] live_digits;
  logic        run;
  logic        sw_clear_n;
  logic [31:0] disp_digits;
  logic        lap_active;
  logic [1:0]  state;
  modport master (
    output key_startstop_n, key_lap_n, key_clear_n, live_digits,
    input  run, sw_clear_n, disp_digits, lap_active, state
  );
  modport slave (
    input  key_startstop_n, key_lap_n, key_clear_n, live_digits,
    output run, sw_clear_n, disp_digits, lap_active, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: debounced start/stop, lap and clear keys driving the run/pause/lap state machine
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input logic             clock,
  input logic             reset,
  stopwatch_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, LAP = 2'b11} state_t;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [2:0]    raw, sync1_q, sync2_q, level_q, level_d, armed_q, armed_d, press_q, press_d;
  logic [1:0]    warm_q;
  logic [CW-1:0] cnt_q [3];
  logic [CW-1:0] cnt_d [3];
  state_t        state_q, state_d;
  logic          run_q, run_d, clr_n_q, clr_n_d;
  logic [31:0]   lap_q, lap_d;
  logic          ss, lp, cl;
  assign raw = {bus.key_clear_n, bus.key_lap_n, bus.key_startstop_n};
  assign ss  = press_q[0];
  assign lp  = press_q[1];
  assign cl  = press_q[2];
  // A key is armed only once it has been seen released after reset, so a key held through reset stays silent
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == LAST) level_d[i] = sync2_q[i];
        else cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    armed_d = armed_q | ({3{warm_q[1]}} & sync2_q);
    press_d = armed_q & level_q & ~level_d;
  end
  always_comb begin
    state_d = state_q;
    clr_n_d = 1'b1;
    lap_d   = lap_q;
    case (state_q)
      IDLE:    if (ss) state_d = RUN;
               else if (cl) clr_n_d = 1'b0;
      RUN:     if (ss) state_d = PAUSE;
               else if (lp) begin
                 state_d = LAP;
                 lap_d   = bus.live_digits;
               end
      LAP:     if (ss) state_d = PAUSE;
               else if (lp) state_d = RUN;
      PAUSE:   if (ss) state_d = RUN;
               else if (cl) begin
                 state_d = IDLE;
                 clr_n_d = 1'b0;
               end
      default: state_d = IDLE;
    endcase
    run_d = (state_d == RUN) || (state_d == LAP);
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
      level_q <= '1;
      armed_q <= '0;
      press_q <= '0;
      warm_q  <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      state_q <= IDLE;
      run_q   <= 1'b0;
      clr_n_q <= 1'b1;
      lap_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      armed_q <= armed_d;
      press_q <= press_d;
      warm_q  <= {warm_q[0], 1'b1};
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      state_q <= state_d;
      run_q   <= run_d;
      clr_n_q <= clr_n_d;
      lap_q   <= lap_d;
    end
  end
  assign bus.state       = state_q;
  assign bus.run         = run_q;
  assign bus.sw_clear_n  = clr_n_q;
  assign bus.lap_active  = (state_q == LAP);
  assign bus.disp_digits = (state_q == LAP) ? lap_q : bus.live_digits;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed checks of debounce, state transitions, lap freeze, clear pulse and reset
module tb_stopwatch_ctrl;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  keys  = 3'b111;
  logic [31:0] live  = 32'h0000_0042;
  int          n_tests = 0, n_fail = 0, n_chg = 0, n_clr = 0;
  logic [1:0]  prev_st = 2'b00;
  stopwatch_ctrl_if sw ();
  assign sw.key_startstop_n = keys[0];
  assign sw.key_lap_n       = keys[1];
  assign sw.key_clear_n     = keys[2];
  assign sw.live_digits     = live;
  stopwatch_ctrl #(.DEBOUNCE_CYCLES(4)) dut (.clock(clock), .reset(reset), .bus(sw));
  always #5 clock = ~clock;
  always @(posedge clock) begin
    #1;
    if (sw.state != prev_st) n_chg++;
    if (!sw.sw_clear_n) n_clr++;
    prev_st = sw.state;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic press(input int k);
    keys[k] = 1'b0;
    tick(10);
    keys[k] = 1'b1;
    tick(10);
  endtask
  initial begin
    tick(2);
    check("rst_state", sw.state, 2'b00);
    check("rst_run", sw.run, 1'b0);
    check("rst_clr", sw.sw_clear_n, 1'b1);
    check("rst_lapact", sw.lap_active, 1'b0);
    reset = 1'b1;
    tick(3);
    check("idle_state", sw.state, 2'b00);
    check("idle_run", sw.run, 1'b0);
    check("idle_clr", sw.sw_clear_n, 1'b1);
    check("idle_disp", sw.disp_digits, 32'h0000_0042);
    n_chg = 0;
    for (int i = 0; i < 6; i++) begin
      keys[0] = i[0];
      tick(2);
    end
    keys[0] = 1'b0;
    tick(10);
    keys[0] = 1'b1;
    tick(10);
    check("bounce_events", n_chg, 1);
    check("bounce_state", sw.state, 2'b01);
    check("bounce_run", sw.run, 1'b1);
    live = 32'h0000_1234;
    press(1);
    check("lap_state", sw.state, 2'b11);
    check("lap_active", sw.lap_active, 1'b1);
    check("lap_run", sw.run, 1'b1);
    live = 32'h0000_1300;
    tick(2);
    check("lap_frozen", sw.disp_digits, 32'h0000_1234);
    press(1);
    check("lap2_state", sw.state, 2'b01);
    check("lap2_disp", sw.disp_digits, 32'h0000_1300);
    check("lap2_active", sw.lap_active, 1'b0);
    n_clr = 0;
    press(2);
    check("run_clr_pulse", n_clr, 0);
    check("run_clr_state", sw.state, 2'b01);
    press(0);
    check("pause_state", sw.state, 2'b10);
    check("pause_run", sw.run, 1'b0);
    n_clr = 0;
    press(2);
    check("clr_pulse_len", n_clr, 1);
    check("clr_state", sw.state, 2'b00);
    press(0);
    press(1);
    check("relap_disp", sw.disp_digits, 32'h0000_1300);
    press(1);
    live = 32'h0000_5555;
    n_chg = 0;
    keys[1:0] = 2'b00;
    tick(10);
    keys[1:0] = 2'b11;
    tick(10);
    check("both_state", sw.state, 2'b10);
    check("both_events", n_chg, 1);
    check("both_lapreg", dut.lap_q, 32'h0000_1300);
    press(0);
    keys[1] = 1'b0;
    tick(10);
    check("hold_lap_state", sw.state, 2'b11);
    keys[0] = 1'b0;
    tick(1);
    reset = 1'b0;
    #1;
    check("async_state", sw.state, 2'b00);
    check("async_run", sw.run, 1'b0);
    check("async_lapact", sw.lap_active, 1'b0);
    check("async_disp", sw.disp_digits, 32'h0000_5555);
    tick(1);
    reset = 1'b1;
    tick(20);
    check("held_ss_ignored", sw.state, 2'b00);
    keys[0] = 1'b1;
    tick(10);
    press(0);
    tick(10);
    check("held_lap_ignored", sw.state, 2'b01);
    keys[1] = 1'b1;
    tick(10);
    press(1);
    check("repress_lap", sw.state, 2'b11);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
